// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch/decode slice.
//   XLEN_DEFAULT     - datapath / PC width
//   RESET_PC_DEFAULT - PC value after reset
//   NOP_INSTR        - bubble instruction, addi x0,x0,0
//   if_id_t          - contents of the IF/ID pipeline register
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]             instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_plus4;
    logic                    valid;
  } if_id_t;

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Signal bundle between the fetch/decode stage and the rest of the core
// (hazard unit, Execute redirect, instruction memory, ID/EX register).
//   slave  : the fetch_decode_stage side
//   master : the core / testbench side
// With FETCH_PERF_CNT_EN defined the bundle also carries the
// StallCntF / FlushCntD performance counters.
interface fetch_decode_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) ();

  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic [XLEN-1:0] PCF;
  logic [31:0]     InstrF;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     StallCntF;
  logic [31:0]     FlushCntD;
`endif

  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD
`ifdef FETCH_PERF_CNT_EN
    , output StallCntF, FlushCntD
`endif
  );

  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD
`ifdef FETCH_PERF_CNT_EN
    , input StallCntF, FlushCntD
`endif
  );

endinterface

// File: rtl/fetch_decode_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (resets to a bubble)
//   stall      : hold current contents
//   flush      : load a bubble; wins over stall
//   d_in       : fetch-side {instr, pc, pc_plus4, valid}
//   d_out      : decode-side registered contents
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  riscv_pkg::if_id_t d_in,
  output riscv_pkg::if_id_t d_out
);

  import riscv_pkg::*;

  if_id_t if_id_d, if_id_q;
  if_id_t bubble;

  always_comb begin
    bubble          = '0;
    bubble.instr    = NOP_INSTR;
  end

  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = bubble;
    end else if (!stall) begin
      if_id_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= bubble;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign d_out = if_id_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch stage plus IF/ID register of the 5-stage RISC-V core.
// Holds the PC, forms PC+4, picks the next PC (redirect > stall > PC+4)
// and registers the fetched instruction into the Decode-stage signals.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_decode_stage_if.slave (hazard controls, redirect,
//                instruction memory address/data, Decode outputs)
// Optional macro FETCH_PERF_CNT_EN adds StallCntF / FlushCntD counters.
// XLEN must equal riscv_pkg::XLEN_DEFAULT because if_id_t is fixed-width.
module fetch_decode_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_stage_if.slave bus
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_plus4;
  if_id_t          if_id_in, if_id_out;

  // Wraps silently at the top of the address space.
  assign pc_plus4 = pc_q + XLEN'(4);

  // Redirect beats stall so a taken branch is never dropped.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.PCSrcE) begin
      pc_d = bus.PCTargetE;
    end else if (bus.StallF) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    if_id_in          = '0;
    if_id_in.instr    = bus.InstrF;
    if_id_in.pc       = pc_q;
    if_id_in.pc_plus4 = pc_plus4;
    if_id_in.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (bus.StallD),
    .flush (bus.FlushD),
    .d_in  (if_id_in),
    .d_out (if_id_out)
  );

  assign bus.PCF      = pc_q;
  assign bus.InstrD   = if_id_out.instr;
  assign bus.PCD      = if_id_out.pc;
  assign bus.PCPlus4D = if_id_out.pc_plus4;
  assign bus.ValidD   = if_id_out.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // A stall cycle that is overridden by a redirect is not a lost cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.StallF && !bus.PCSrcE) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.FlushD) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCntF = stall_cnt_q;
  assign bus.FlushCntD = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage. Expected Decode/PC values
// are pushed to a scoreboard queue as each cycle is driven and popped
// after the clock edge. Counter checks are compiled in with FETCH_PERF_CNT_EN.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I_A = 32'h0050_0093;
  localparam logic [31:0] I_B = 32'h0060_0113;
  localparam logic [31:0] I_C = 32'h0020_81b3;

  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  typedef struct {
    logic        sf, sd, fd, ps;
    logic [31:0] tgt;
    logic [31:0] pcf, instr, pcd, pc4;
    logic        valid;
  } row_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  fetch_decode_stage_if #(.XLEN(32)) bus ();

  fetch_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   mem_word = I_A;
      32'h4:   mem_word = I_B;
      32'h8:   mem_word = I_C;
      default: mem_word = 32'ha5a5_0000 ^ addr;
    endcase
  endfunction

  assign bus.InstrF = mem_word(bus.PCF);

  task automatic drive(input row_t r);
    exp_t e;
    bus.StallF    = r.sf;
    bus.StallD    = r.sd;
    bus.FlushD    = r.fd;
    bus.PCSrcE    = r.ps;
    bus.PCTargetE = r.tgt;
    e = '{pcf: r.pcf, instr: r.instr, pcd: r.pcd, pc4: r.pc4, valid: r.valid};
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = '0;
  endtask

  function automatic row_t idle(input logic [31:0] pcf, instr, pcd, pc4, input logic valid);
    idle = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, pcf, instr, pcd, pc4, valid};
  endfunction

  task automatic test_reset();
    exp_t e;
    sb.push_back('{pcf: 32'h0, instr: NOP, pcd: 32'h0, pc4: 32'h0, valid: 1'b0});
    e = sb.pop_front();
    n_cmp++;
    if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
        bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
      n_err++;
      $display("FAIL reset: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
               bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
               e.pcf, e.instr, e.pcd, e.pc4, e.valid);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (bus.StallCntF !== 32'd0 || bus.FlushCntD !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got StallCntF=%0d FlushCntD=%0d, want 0 0", bus.StallCntF, bus.FlushCntD);
    end
`endif
  endtask

  task automatic test_free_run();
    row_t rows[3];
    exp_t e;
    rows[0] = idle(32'h0, NOP, 32'h0, 32'h0, 1'b0);
    rows[1] = idle(32'h4, I_A, 32'h0, 32'h4, 1'b1);
    rows[2] = idle(32'h8, I_B, 32'h4, 32'h8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) sb.push_back('{rows[0].pcf, rows[0].instr, rows[0].pcd, rows[0].pc4, rows[0].valid});
      else drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL free_run[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[4];
    exp_t e;
    for (int i = 0; i < 3; i++)
      rows[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, I_B, 32'h4, 32'h8, 1'b1};
    rows[3] = idle(32'hc, I_C, 32'h8, 32'hc, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL stall[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_redirect();
    row_t rows[2];
    exp_t e;
    rows[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h40, NOP, 32'h0, 32'h0, 1'b0};
    rows[1] = idle(32'h44, mem_word(32'h40), 32'h40, 32'h44, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL redirect[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (bus.StallCntF !== 32'd3 || bus.FlushCntD !== 32'd1) begin
      n_err++;
      $display("FAIL perf_cnt: got StallCntF=%0d FlushCntD=%0d, want 3 1", bus.StallCntF, bus.FlushCntD);
    end
`endif
  endtask

  task automatic test_priority();
    row_t rows[4];
    exp_t e;
    rows[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h48, NOP, 32'h0, 32'h0, 1'b0};
    rows[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80, mem_word(32'h48), 32'h48, 32'h4c, 1'b1};
    rows[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, mem_word(32'h80), 32'h80, 32'h84, 1'b1};
    rows[3] = rows[2];
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL priority[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_wrap();
    row_t rows[4];
    exp_t e;
    rows[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 32'h102, NOP, 32'h0, 32'h0, 1'b0};
    rows[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hffff_fffc, 32'hffff_fffc, NOP, 32'h0, 32'h0, 1'b0};
    rows[2] = idle(32'h0, mem_word(32'hffff_fffc), 32'hffff_fffc, 32'h0, 1'b1);
    rows[3] = idle(32'h4, I_A, 32'h0, 32'h4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL wrap[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
    end
  endtask

  task automatic test_async_reset();
    row_t rows[4];
    exp_t e;
    // Assert mid-cycle: the check happens before any further rising edge.
    #3;
    rst_n = 1'b0;
    #1;
    rows[0] = idle(32'h0, NOP, 32'h0, 32'h0, 1'b0);
    rows[1] = rows[0];
    rows[2] = idle(32'h4, I_A, 32'h0, 32'h4, 1'b1);
    rows[3] = idle(32'h8, I_B, 32'h4, 32'h8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      if (i < 2) sb.push_back('{rows[i].pcf, rows[i].instr, rows[i].pcd, rows[i].pc4, rows[i].valid});
      else drive(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (bus.PCF !== e.pcf || bus.InstrD !== e.instr || bus.PCD !== e.pcd ||
          bus.PCPlus4D !== e.pc4 || bus.ValidD !== e.valid) begin
        n_err++;
        $display("FAIL async_reset[%0d]: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want %h %h %h %h %b",
                 i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD,
                 e.pcf, e.instr, e.pcd, e.pc4, e.valid);
      end
`ifdef FETCH_PERF_CNT_EN
      n_cmp++;
      if (bus.StallCntF !== 32'd0 || bus.FlushCntD !== 32'd0) begin
        n_err++;
        $display("FAIL async_reset_cnt[%0d]: got StallCntF=%0d FlushCntD=%0d, want 0 0",
                 i, bus.StallCntF, bus.FlushCntD);
      end
`endif
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_free_run();
    test_stall();
    test_redirect();
    test_priority();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Holds the PC, computes PC+4, and selects the next PC between sequential and the redirect resolved in Execute.
- Issues the instruction-memory address and registers {InstrF, PCF, PCPlus4F} into the Decode-stage signals that feed the ID/EX register.
- Takes stall and flush controls from the hazard unit.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on flush and reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  replace IF/ID contents with a bubble.
- PCSrcE  in  1  redirect taken (branch taken, jal or jalr), from Execute.
- PCTargetE  in  XLEN  redirect target, from Execute.
- PCF  out  XLEN  current fetch PC; drives the instruction memory address.
- InstrF  in  32  instruction-memory read data (combinational read of PCF).
- InstrD  out  32  registered instruction.
- PCD  out  XLEN  registered PC.
- PCPlus4D  out  XLEN  registered PC+4.
- ValidD  out  1  Decode holds a real instruction; 0 for a bubble.

Behaviour:
- Reset (async assert, sync-free deassert):
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Reset takes effect mid-operation, overriding every other input immediately.
- PCPlus4F = PCF + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- Next PC, priority order:
  - PCSrcE=1 → PCTargetE.
  - Else StallF=1 → PCF held.
  - Else → PCPlus4F.
  - Redirect beats stall. The hazard unit never stalls F while redirecting, but if both occur the redirect is taken, so no branch is lost.
- PCTargetE bits [1:0] are passed through unchanged; misalignment is not checked here.
- IF/ID register, priority order:
  - FlushD=1 → InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Flush beats StallD.
  - Else StallD=1 → all D outputs held, including ValidD.
  - Else → InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- Latency:
  - Instruction at PCF appears on InstrD 1 cycle later when unstalled.
  - Redirect: PCF=PCTargetE the cycle after PCSrcE. The hazard unit asserts FlushD in the same cycle as PCSrcE, killing the wrong-path fetch.
- First cycle after reset release: PCF=RESET_PC, ValidD=0. On the next edge, ValidD=1 and InstrD=mem[RESET_PC].
- StallF=1 with StallD=0 is legal:
  - Same PC fetched again, D re-latches the same instruction with ValidD=1.
  - The hazard unit never produces this combination; the bench checks it anyway.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs StallCntF (32-bit, increments each cycle StallF=1 and PCSrcE=0) and FlushCntD (32-bit, increments each cycle FlushD=1).
  - Both reset to 0 and wrap on overflow.
  - Both are updated during reset release like any other register.
- Undefined: those ports and registers do not exist; behaviour otherwise identical.

Decomposition:
- Package riscv_pkg holds:
  - XLEN_DEFAULT.
  - NOP_INSTR constant.
  - RESET_PC_DEFAULT.
  - typedef if_id_t, a packed struct {instr, pc, pc_plus4, valid}.
- One sub-module, if_id_reg, is natural: the IF/ID register with stall/flush priority, taking/producing if_id_t.
- The top handles PC, next-PC mux, adder and optional counters.

Test Plan:
- Reset then free run, memory with mem[0]=A, mem[4]=B, mem[8]=C: PCF sequence 0,4,8,12. InstrD: NOP/ValidD=0, then A, B, C with PCD 0,4,8.
- StallF=StallD=1 for 3 cycles at PCF=8: PCF stays 8, InstrD stays B/PCD=4 for 3 cycles. On release, InstrD=C.
- PCSrcE=1, PCTargetE=0x40, FlushD=1 in one cycle at PCF=0xC: next PCF=0x40, InstrD=NOP, ValidD=0. Following cycle InstrD=mem[0x40], PCD=0x40.
- FlushD=1 and StallD=1 together: D becomes bubble (flush wins). PCSrcE=1 with StallF=1: PCF=PCTargetE (redirect wins).
- Wrap: force PCTargetE=0xFFFF_FFFC: next cycle PCF=0xFFFF_FFFC, then PCF=0, PCPlus4D=0.
- rst_n pulsed low mid-run between clock edges: outputs reach reset values immediately without a clock edge. With FETCH_PERF_CNT_EN, counters read 0; after the 3-stall and 1-flush scenarios, StallCntF=3 and FlushCntD=1.
